// File: rtl/select_max.sv
// rtl/select_max.sv - sequential signed argmax over N scores, one element per clock
// Optional SELECT_MAX_SNAPSHOT_EN copies in_data into a local bank on the start edge.
module select_max #(
    parameter int N      = 10,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] in_data [0:N-1],
    output logic        [IDX_W-1:0]  digit,
    output logic signed [DATA_W-1:0] max,
    output logic                     layer_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Declaration initialisers match reset values so the block works without reset.
    state_t                    state_q = S_IDLE;
    state_t                    state_d;
    logic        [IDX_W-1:0]   idx_q   = '0;
    logic        [IDX_W-1:0]   idx_d;
    logic        [IDX_W-1:0]   digit_q = '0;
    logic        [IDX_W-1:0]   digit_d;
    logic signed [DATA_W-1:0]  max_q   = '0;
    logic signed [DATA_W-1:0]  max_d;
    logic                      done_q  = 1'b0;
    logic                      done_d;

    logic signed [DATA_W-1:0]  src [0:N-1];
    logic signed [DATA_W-1:0]  cur;
    logic                      start;

    assign start = (state_q == S_IDLE) && enable;

`ifdef SELECT_MAX_SNAPSHOT_EN
    logic signed [DATA_W-1:0] bank_q [0:N-1] = '{default: '0};
    logic signed [DATA_W-1:0] bank_d [0:N-1];

    always_comb begin
        bank_d = bank_q;
        if (start) begin
            bank_d = in_data;
        end
    end

    always_ff @(posedge clk) begin
        bank_q <= bank_d;
    end

    always_comb begin
        src = bank_q;
    end
`else
    always_comb begin
        src = in_data;
    end
`endif

    // Element under inspection; idx never leaves 1..N-1 while scanning.
    always_comb begin
        cur = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur = src[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        digit_d = digit_q;
        max_d   = max_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    max_d   = in_data[0];
                    digit_d = '0;
                    idx_d   = IDX_W'(1);
                    state_d = S_SCAN;
                    if (N == 1) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_SCAN: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end else begin
                    // Strict compare keeps the lowest index among equal maxima.
                    if (cur > max_q) begin
                        max_d   = cur;
                        digit_d = idx_q;
                    end
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_W'(N - 1)) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            digit_q <= '0;
            max_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            digit_q <= digit_d;
            max_q   <= max_d;
            done_q  <= done_d;
        end
    end

    assign digit      = digit_q;
    assign max        = max_q;
    assign layer_done = done_q;

endmodule

// File: tb/tb_select_max.sv
// tb/tb_select_max.sv - randomized self-checking bench for select_max against an argmax model
`timescale 1ns/1ps
module tb_select_max;

    localparam int N = 10;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                enable = 1'b0;
    logic signed [15:0]  din [0:N-1];
    logic        [7:0]   digit;
    logic signed [15:0]  mx;
    logic                layer_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 clk = ~clk;

    select_max #(.N(N), .DATA_W(16), .IDX_W(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .in_data(din),
        .digit(digit), .max(mx), .layer_done(layer_done)
    );

    // Reference: find the largest value, then the first position holding it.
    function automatic void ref_argmax(input logic signed [15:0] a [0:N-1],
                                       output logic [7:0] di, output logic signed [15:0] m);
        int best;
        best = -40000;
        for (int i = 0; i < N; i++) if (int'(a[i]) > best) best = int'(a[i]);
        m  = 16'(best);
        di = 8'd0;
        for (int i = N - 1; i >= 0; i--) if (int'(a[i]) == best) di = 8'(i);
    endfunction

    task automatic go_idle();
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_scan(output int edges);
        @(negedge clk);
        enable = 1'b1;
        edges  = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (layer_done) begin
                edges = n;
                break;
            end
        end
    endtask

    task automatic test_directed_85();
        int n;
        din = '{16'sd0, 16'sd0, 16'sd5, 16'sd85, 16'sd0, 16'sd10, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        #20;
        n_checks++;
        if (layer_done !== 1'b0 || digit !== 8'd0 || mx !== 16'sd0) begin
            n_fail++;
            $display("FAIL powerup: done=%b digit=%0d max=%0d, want 0/0/0", layer_done, digit, mx);
        end
        #125;
        enable = 1'b1;
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (layer_done) begin
                n = k;
                break;
            end
        end
        n_checks++;
        if (n !== 10) begin
            n_fail++;
            $display("FAIL lat_85: edges=%0d want 10", n);
        end
        n_checks++;
        if (digit !== 8'd3 || mx !== 16'sd85) begin
            n_fail++;
            $display("FAIL result_85: digit=%0d max=%0d want 3/85", digit, mx);
        end
        while ($time < 2645) #1;
        n_checks++;
        if (layer_done !== 1'b1 || digit !== 8'd3 || mx !== 16'sd85) begin
            n_fail++;
            $display("FAIL hold_2645: done=%b digit=%0d max=%0d want 1/3/85", layer_done, digit, mx);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        enable = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (layer_done !== 1'b0 || digit !== 8'd0 || mx !== 16'sd0) begin
            n_fail++;
            $display("FAIL reset: done=%b digit=%0d max=%0d want 0/0/0", layer_done, digit, mx);
        end
        reset = 1'b0;
    endtask

    task automatic test_negative();
        int n;
        go_idle();
        din = '{-16'sd5, -16'sd3, -16'sd9, -16'sd100, 16'sh8000, -16'sd4, -16'sd3, -16'sd7, -16'sd8, -16'sd6};
        do_scan(n);
        n_checks++;
        if (n !== 10 || digit !== 8'd1 || mx !== -16'sd3) begin
            n_fail++;
            $display("FAIL negative_tie: edges=%0d digit=%0d max=%0d want 10/1/-3", n, digit, mx);
        end
    endtask

    task automatic test_latency_edge();
        go_idle();
        for (int i = 0; i < N - 1; i++) din[i] = 16'(i + 1);
        din[N-1] = 16'sd32767;
        @(negedge clk);
        enable = 1'b1;
        repeat (8) @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (layer_done !== 1'b0) begin
            n_fail++;
            $display("FAIL edge9: done=%b want 0", layer_done);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (layer_done !== 1'b1 || digit !== 8'd9 || mx !== 16'sd32767) begin
            n_fail++;
            $display("FAIL edge10: done=%b digit=%0d max=%0d want 1/9/32767", layer_done, digit, mx);
        end
    endtask

    task automatic test_reset_midscan();
        logic [7:0] ed;
        logic signed [15:0] em;
        int n;
        go_idle();
        for (int i = 0; i < N; i++) din[i] = 16'($urandom);
        ref_argmax(din, ed, em);
        @(negedge clk);
        enable = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (layer_done !== 1'b0 || digit !== 8'd0 || mx !== 16'sd0) begin
            n_fail++;
            $display("FAIL midscan_reset: done=%b digit=%0d max=%0d want 0/0/0", layer_done, digit, mx);
        end
        reset = 1'b0;
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (layer_done) begin
                n = k;
                break;
            end
        end
        n_checks++;
        if (n !== 10 || digit !== ed || mx !== em) begin
            n_fail++;
            $display("FAIL after_reset_scan: edges=%0d digit=%0d max=%0d want 10/%0d/%0d", n, digit, mx, ed, em);
        end
    endtask

    task automatic test_enable_drop();
        logic [7:0] hd;
        logic signed [15:0] hm;
        int n;
        hd = digit;
        hm = mx;
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (layer_done !== 1'b0 || digit !== hd || mx !== hm) begin
            n_fail++;
            $display("FAIL enable_drop: done=%b digit=%0d max=%0d want 0/%0d/%0d", layer_done, digit, mx, hd, hm);
        end
        for (int i = 0; i < N; i++) din[i] = 16'sd0;
        din[0] = 16'sd9;
        do_scan(n);
        n_checks++;
        if (n !== 10 || digit !== 8'd0 || mx !== 16'sd9) begin
            n_fail++;
            $display("FAIL restart_9: edges=%0d digit=%0d max=%0d want 10/0/9", n, digit, mx);
        end
    endtask

    task automatic test_done_hold();
        repeat (5) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (layer_done !== 1'b1 || digit !== 8'd0 || mx !== 16'sd9) begin
                n_fail++;
                $display("FAIL done_hold: done=%b digit=%0d max=%0d want 1/0/9", layer_done, digit, mx);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] ed;
        logic signed [15:0] em;
        int n;
        int mode;
        for (int t = 0; t < 30; t++) begin
            go_idle();
            mode = $urandom_range(0, 3);
            for (int i = 0; i < N; i++) begin
                case (mode)
                    0: din[i] = 16'($signed($urandom_range(0, 8)) - 4);
                    1: din[i] = 16'($urandom);
                    2: din[i] = ($urandom_range(0, 1) != 0) ? 16'sh8000 : 16'sh7fff;
                    default: din[i] = (t[0]) ? 16'sh8000 : 16'sd7;
                endcase
            end
            ref_argmax(din, ed, em);
            do_scan(n);
            n_checks++;
            if (n !== 10 || digit !== ed || mx !== em) begin
                n_fail++;
                $display("FAIL random_%0d: edges=%0d digit=%0d max=%0d want 10/%0d/%0d", t, n, digit, mx, ed, em);
            end
        end
    endtask

`ifdef SELECT_MAX_SNAPSHOT_EN
    task automatic test_snapshot();
        int n;
        go_idle();
        din = '{16'sd0, 16'sd0, 16'sd5, 16'sd85, 16'sd0, 16'sd10, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #1;
        din[3] = 16'sd0;
        n = -1;
        for (int k = 2; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (layer_done) begin
                n = k;
                break;
            end
        end
        n_checks++;
        if (n !== 10 || digit !== 8'd3 || mx !== 16'sd85) begin
            n_fail++;
            $display("FAIL snapshot: edges=%0d digit=%0d max=%0d want 10/3/85", n, digit, mx);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < N; i++) din[i] = 16'sd0;
        test_directed_85();
        test_reset();
        test_negative();
        test_latency_edge();
        test_reset_midscan();
        test_enable_drop();
        test_done_hold();
        test_random();
`ifdef SELECT_MAX_SNAPSHOT_EN
        test_snapshot();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
